// File: rtl/ysyx_22041211_ifu_prefetch.sv
// ysyx_22041211_ifu_prefetch
//   Instruction-fetch unit with a prefetch queue. Issues in-order word fetches
//   on a valid/ready request channel and takes in-order response beats. Each
//   beat is tagged with its PC and queued for the decoder. A redirect flushes
//   the queue, restarts fetch at the new PC and discards any beats still in
//   flight.
//
// Ports
//   clk, rst           clock (posedge), synchronous active-high reset
//   redirect_valid_i   flush + restart this cycle
//   redirect_pc_i      restart PC (low two bits ignored)
//   mem_req_*          fetch request channel (valid/ready, word address)
//   mem_resp_*         response beats, one per accepted request, in order
//   inst_valid_o/ready queue head handshake to the decoder
//   inst_o, inst_pc_o  queue head instruction and PC (0 when empty)
//
// Build option
//   YSYX_22041211_IFU_PERF_EN adds perf_fetch_o (queue pushes) and
//   perf_stall_o (cycles with decoder ready but queue empty), both saturating.

module ysyx_22041211_ifu_prefetch #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  MAX_OUT    = 2,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = ADDR_LEN'(32'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_LEN-1:0] mem_resp_data_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [DATA_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o
`ifdef YSYX_22041211_IFU_PERF_EN
    ,
    output logic [31:0]         perf_fetch_o,
    output logic [31:0]         perf_stall_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       ONE   = CW'(1);
    localparam logic [ADDR_LEN-1:0] STEP  = ADDR_LEN'(4);
    localparam logic [ADDR_LEN-1:0] ALIGN = ~ADDR_LEN'(3);

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_LEN-1:0] r_fetch_pc, r_resp_pc;
    logic [ADDR_LEN-1:0] r_pc_q   [FIFO_DEPTH];
    logic [DATA_LEN-1:0] r_inst_q [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [CW-1:0]       r_count, r_out, r_drop;
    logic [CW-1:0]       w_drop_nxt;
    logic [CW:0]         w_credit;
    logic                w_req_fire, w_push, w_pop;
    logic [ADDR_LEN-1:0] w_redir_pc;

    // Queue slots already promised: entries held plus beats still in flight.
    // Issuing only while this is below depth guarantees a push never overflows.
    assign w_credit        = {1'b0, r_count} + {1'b0, r_out};
    assign mem_req_valid_o = !rst && (r_state == S_RUN)
                           && (w_credit < (CW+1)'(FIFO_DEPTH))
                           && (r_out < CW'(MAX_OUT));
    assign mem_req_addr_o  = r_fetch_pc;
    assign w_req_fire      = mem_req_valid_o && mem_req_ready_i;

    assign inst_valid_o = (r_count != '0);
    assign inst_o       = inst_valid_o ? r_inst_q[r_rptr] : '0;
    assign inst_pc_o    = inst_valid_o ? r_pc_q[r_rptr]   : '0;

    // Redirect wins over queue traffic in the same cycle.
    assign w_push     = mem_resp_valid_i && (r_drop == '0) && !redirect_valid_i;
    assign w_pop      = inst_valid_o && inst_ready_i && !redirect_valid_i;
    assign w_redir_pc = redirect_pc_i & ALIGN;

    // Beats to discard: everything in flight after this cycle's traffic.
    always_comb begin
        w_drop_nxt  = r_drop;
        if (redirect_valid_i)
            w_drop_nxt = r_out + CW'(w_req_fire) - CW'(mem_resp_valid_i);
        else if (mem_resp_valid_i && (r_drop != '0))
            w_drop_nxt = r_drop - ONE;
        w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_out <= r_out + CW'(w_req_fire) - CW'(mem_resp_valid_i);
            if (redirect_valid_i) begin
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + STEP;
                    r_wptr    <= r_wptr + PW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_pc_q[r_wptr]   <= r_resp_pc;
            r_inst_q[r_wptr] <= mem_resp_data_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

`ifdef YSYX_22041211_IFU_PERF_EN
    logic [31:0] r_perf_fetch, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push && (r_perf_fetch != '1))
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (inst_ready_i && !inst_valid_o && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule
